// File: rtl/approx_error_sweeper.sv
// approx_error_sweeper
//   Drives every {b,a} operand pair into an external approximate-multiplier
//   error comparator, counts how many patterns raise the error flag and keeps
//   the first failing pattern. Results are reported through start/busy/done.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   start           begin a sweep (only acted on in IDLE)
//   a_out, b_out    operands presented to the comparator
//   err_in          comparator error flag, SAMPLE_LAT cycles behind a_out/b_out
//   busy            sweep in progress (RUN or DRAIN)
//   done            one-cycle pulse when results are final
//   err_count       number of failing patterns
//   first_err_vec   {b,a} of the earliest failing pattern
//   first_err_valid first_err_vec holds a captured pattern
module approx_error_sweeper #(
    parameter int OP_W       = 2,
    parameter int SAMPLE_LAT = 0,
    parameter int CNT_W      = 2*OP_W+1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [OP_W-1:0]   a_out,
    output logic [OP_W-1:0]   b_out,
    input  logic              err_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [2*OP_W-1:0] first_err_vec,
    output logic              first_err_valid
);
    localparam int PW = 2*OP_W;
    // One extra counter bit keeps the terminal pattern distinct from a wrapped 0.
    localparam logic [PW:0] LAST = {1'b0, {PW{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [PW:0]   p;
    logic [2:0]    dcnt;
    logic [PW-1:0] cur_pat;
    logic          run_vld;
    logic          sc_vld;
    logic [PW-1:0] sc_pat;
    logic          accept;

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (p == LAST) state_nxt = (SAMPLE_LAT > 0) ? DRAIN : DONE;
            DRAIN:   if (dcnt == 3'(SAMPLE_LAT-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                p <= '0;
            else if (state == RUN)
                p <= p + 1'b1;
            dcnt <= (state == DRAIN) ? dcnt + 3'd1 : 3'd0;
        end
    end

    // DRAIN holds the last pattern, which is always all-ones.
    always_comb begin
        cur_pat = '0;
        case (state)
            RUN:     cur_pat = p[PW-1:0];
            DRAIN:   cur_pat = '1;
            default: cur_pat = '0;
        endcase
    end

    assign {b_out, a_out} = cur_pat;
    assign run_vld        = (state == RUN);
    assign busy           = (state == RUN) || (state == DRAIN);
    assign done           = (state == DONE);

    // Tag/pattern delay line aligning each driven pattern with its err_in.
    generate
        if (SAMPLE_LAT == 0) begin : g_nolat
            assign sc_vld = run_vld;
            assign sc_pat = cur_pat;
        end else begin : g_lat
            logic [SAMPLE_LAT-1:0]         vld_pipe;
            logic [SAMPLE_LAT-1:0][PW-1:0] pat_pipe;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    pat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= run_vld;
                    pat_pipe[0] <= cur_pat;
                    for (int i = 1; i < SAMPLE_LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        pat_pipe[i] <= pat_pipe[i-1];
                    end
                end
            end
            assign sc_vld = vld_pipe[SAMPLE_LAT-1];
            assign sc_pat = pat_pipe[SAMPLE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (sc_vld && err_in) begin
            err_count <= err_count + CNT_W'(1);
            if (!first_err_valid) begin
                first_err_vec   <= sc_pat;
                first_err_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_approx_error_sweeper.sv
module tb_approx_error_sweeper;
    logic clk = 0;
    logic rst_n, start;
    logic [1:0] mode;  // 0: err tied 0, 1: err tied 1, 2: 2-bit approx multiplier

    logic [1:0] a0, b0, a2, b2;
    logic       err0, err2, busy0, busy2, done0, done2, fv0, fv2;
    logic [4:0] cnt0, cnt2;
    logic [3:0] vec0, vec2;
    logic [3:0] d1, d2;

    always #5 clk = ~clk;

    // Approx 2x2 multiplier differs from exact only at a=3,b=3 (7 vs 9).
    function automatic logic cmp(input logic [1:0] m, input logic [3:0] ba);
        case (m)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            default: return (ba == 4'hF);
        endcase
    endfunction

    assign err0 = cmp(mode, {b0, a0});
    always @(posedge clk) begin
        d1 <= {b2, a2};
        d2 <= d1;
    end
    assign err2 = cmp(mode, d2);

    approx_error_sweeper #(.OP_W(2), .SAMPLE_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a0), .b_out(b0),
        .err_in(err0), .busy(busy0), .done(done0), .err_count(cnt0),
        .first_err_vec(vec0), .first_err_valid(fv0));

    approx_error_sweeper #(.OP_W(2), .SAMPLE_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a2), .b_out(b2),
        .err_in(err2), .busy(busy2), .done(done2), .err_count(cnt2),
        .first_err_vec(vec2), .first_err_valid(fv2));

    typedef struct {
        logic [4:0] cnt;
        logic [3:0] vec;
        logic       vld;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc[2]   = '{0, 0};
    logic pbusy[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: tracks the cycle index of each sweep, checks the driven
    // pattern sequence, and scores results whenever done is seen.
    task automatic mon_step(input int id, input logic bsy, input logic dn,
                            input logic [3:0] ab, input logic [4:0] cnt,
                            input logic [3:0] vec, input logic vld);
        exp_t e;
        int   lat = (id == 0) ? 0 : 2;
        if (bsy && !pbusy[id]) cyc[id] = 1;
        else if (cyc[id] != 0) cyc[id]++;
        pbusy[id] = bsy;
        if (bsy) begin
            if (cyc[id] <= 16) chk($sformatf("pattern%0d c%0d", id, cyc[id]), 32'(ab), 32'(cyc[id]-1));
            else               chk($sformatf("drainpat%0d c%0d", id, cyc[id]), 32'(ab), 32'hF);
        end
        if (dn) begin
            chk($sformatf("done_busy%0d", id), 32'(bsy), 0);
            chk($sformatf("done_cycle%0d", id), 32'(cyc[id]), 32'(17 + lat));
            if ((id == 0 && q0.size() == 0) || (id == 1 && q2.size() == 0)) begin
                total++;
                $display("FAIL unexpected_done%0d: got done expected none", id);
            end else begin
                e = (id == 0) ? q0.pop_front() : q2.pop_front();
                chk($sformatf("err_count%0d", id), 32'(cnt), 32'(e.cnt));
                chk($sformatf("first_err_vec%0d", id), 32'(vec), 32'(e.vec));
                chk($sformatf("first_err_valid%0d", id), 32'(vld), 32'(e.vld));
            end
            cyc[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, busy0, done0, {b0, a0}, cnt0, vec0, fv0);
        mon_step(1, busy2, done2, {b2, a2}, cnt2, vec2, fv2);
    end

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy0"}, 32'(busy0), 0);
        chk({tag, " done0"}, 32'(done0), 0);
        chk({tag, " ab0"},   32'({b0, a0}), 0);
        chk({tag, " cnt0"},  32'(cnt0), 0);
        chk({tag, " vec0"},  32'(vec0), 0);
        chk({tag, " fv0"},   32'(fv0), 0);
        chk({tag, " busy2"}, 32'(busy2), 0);
        chk({tag, " ab2"},   32'({b2, a2}), 0);
        chk({tag, " cnt2"},  32'(cnt2), 0);
        chk({tag, " fv2"},   32'(fv2), 0);
    endtask

    task automatic run_sweep(input logic [1:0] m, input logic [4:0] ec,
                             input logic [3:0] ev, input logic efv, input bit repulse);
        exp_t e;
        @(posedge clk); #1;
        mode  = m;
        e.cnt = ec; e.vec = ev; e.vld = efv;
        q0.push_back(e);
        q2.push_back(e);
        start = 1;
        @(posedge clk); #1;  // E0
        start = 0;
        if (repulse) begin
            repeat (4) @(posedge clk);
            #1 start = 1;    // cycle 5
            @(posedge clk); #1 start = 0;
            repeat (11) @(posedge clk);
            #1 start = 1;    // cycle 17: dut0 in DONE, dut2 in DRAIN
            @(posedge clk); #1 start = 0;
        end
        for (int i = 0; i < 40 && (q0.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q2.size() != 0) begin
            total++;
            $display("FAIL done_timeout: got pending %0d/%0d expected 0/0", q0.size(), q2.size());
            q0.delete();
            q2.delete();
        end
        repeat (4) @(posedge clk);
        #1;
        chk("hold busy0", 32'(busy0), 0);
        chk("hold busy2", 32'(busy2), 0);
        chk("hold cnt0", 32'(cnt0), 32'(ec));
        chk("hold cnt2", 32'(cnt2), 32'(ec));
        chk("hold vec0", 32'(vec0), 32'(ev));
        chk("hold fv2", 32'(fv2), 32'(efv));
    endtask

    initial begin
        rst_n = 0; start = 0; mode = 0;
        repeat (2) @(posedge clk);
        #1 chk_idle_zero("reset");
        rst_n = 1;

        run_sweep(2'd0, 5'd0,  4'h0, 1'b0, 1'b0);  // T1 tied 0
        run_sweep(2'd2, 5'd1,  4'hF, 1'b1, 1'b0);  // T2/T4 approx comparator
        run_sweep(2'd1, 5'd16, 4'h0, 1'b1, 1'b0);  // T3 tied 1, full count
        run_sweep(2'd2, 5'd1,  4'hF, 1'b1, 1'b1);  // T5 re-pulsed start ignored

        // T6: reset in cycle 8 of RUN aborts the sweep with no done.
        @(posedge clk); #1;
        mode  = 2'd1;
        start = 1;
        @(posedge clk); #1 start = 0;
        repeat (7) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1;
        chk_idle_zero("midreset");
        rst_n = 1;
        repeat (25) @(posedge clk);
        run_sweep(2'd2, 5'd1, 4'hF, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
